apb_protocol_checker: RTL

APB_PROTOCOL_CHECKER -- requirements
Module: apb_protocol_checker

---
 rtl/apb_chk_pkg.sv | 22 ++
 rtl/apb_chk_wait_timer.sv | 33 +++
 rtl/apb_protocol_checker.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/apb_chk_pkg.sv
// Shared types and constants for the passive APB protocol checker.
// Error indices are bit positions in err_vec / err_pulse.
package apb_chk_pkg;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_e;

  localparam int ERR_N               = 7;
  localparam int ERR_SEL_MULTI       = 0;
  localparam int ERR_ENABLE_NO_SETUP = 1;
  localparam int ERR_ENABLE_MISSING  = 2;
  localparam int ERR_UNSTABLE        = 3;
  localparam int ERR_TIMEOUT         = 4;
  localparam int ERR_SLVERR_MISMATCH = 5;
  localparam int ERR_SLVERR_STRAY    = 6;

  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/apb_chk_wait_timer.sv
// Counts wait samples of one APB access; expired is a combinational flag
// raised on the tick that brings the count to MAX_WAIT.
module apb_chk_wait_timer
  import apb_chk_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic start,
  input  logic tick,
  input  logic stop,
  output logic expired
);

  logic [WAIT_CNT_W-1:0] wait_cnt;

  // start loads 1 because the SETUP sample with pready low is the first wait.
  always_ff @(posedge pclk) begin
    if (!preset) begin
      wait_cnt <= '0;
    end else if (stop) begin
      wait_cnt <= '0;
    end else if (start) begin
      wait_cnt <= WAIT_CNT_W'(1);
    end else if (tick && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end
  end

  assign expired = tick && (wait_cnt >= WAIT_CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker: tracks IDLE/SETUP/ACCESS from sampled bus
// signals and reports sticky/pulsed violation flags plus transfer counts.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SEL    = 4,
  parameter int MAX_WAIT   = 16,
  parameter int ADDR_LIMIT = 32,
  parameter int CNT_W      = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NUM_SEL-1:0] psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              clr,
  output logic [ERR_N-1:0]  err_vec,
  output logic [ERR_N-1:0]  err_pulse,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        phase
);

  localparam logic [1:0] S_IDLE   = PH_IDLE;
  localparam logic [1:0] S_SETUP  = PH_SETUP;
  localparam logic [1:0] S_ACCESS = PH_ACCESS;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);

  logic [1:0]         state, state_nxt;
  logic [ADDR_W-1:0]  cap_addr;
  logic               cap_write;
  logic [DATA_W-1:0]  cap_wdata;
  logic [NUM_SEL-1:0] cap_sel;

  logic sel, multi, capture, complete;
  logic timer_start, timer_tick, timer_stop, expired;
  logic enable_missing, timeout, unstable, slverr_exp, any_flag;
  logic [ERR_N-1:0] flags;

  assign sel   = |psel;
  assign multi = (psel & (psel - NUM_SEL'(1))) != '0;

  // Handshake: a transfer opens with psel high and penable low (SETUP);
  // it completes on the first sample with penable high and pready high,
  // and every pready-low sample with penable high is one wait state.
  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    complete       = 1'b0;
    timer_start    = 1'b0;
    timer_tick     = 1'b0;
    enable_missing = 1'b0;
    timeout        = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel && !penable) begin
          state_nxt = S_SETUP;
          capture   = 1'b1;
        end
      end
      S_SETUP: begin
        if (sel && penable) begin
          if (pready) begin
            complete  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            timer_start = 1'b1;
            state_nxt   = S_ACCESS;
          end
        end else begin
          enable_missing = 1'b1;
          state_nxt      = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (pready) begin
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          timer_tick = 1'b1;
          if (expired) begin
            timeout   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign timer_stop = (state_nxt == S_IDLE);

  apb_chk_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .pclk   (pclk),
    .preset (preset),
    .start  (timer_start),
    .tick   (timer_tick),
    .stop   (timer_stop),
    .expired(expired)
  );

  // Write data only has to hold on writes; reads may leave pwdata floating.
  assign unstable = ((state == S_SETUP) || (state == S_ACCESS)) && sel && penable &&
                    ((paddr != cap_addr) || (pwrite != cap_write) || (psel != cap_sel) ||
                     (cap_write && (pwdata != cap_wdata)));

  assign slverr_exp = (cap_addr > LIMIT);

  always_comb begin
    flags                      = '0;
    flags[ERR_SEL_MULTI]       = multi;
    flags[ERR_ENABLE_NO_SETUP] = (state == S_IDLE) && penable;
    flags[ERR_ENABLE_MISSING]  = enable_missing;
    flags[ERR_UNSTABLE]        = unstable;
    flags[ERR_TIMEOUT]         = timeout;
    flags[ERR_SLVERR_MISMATCH] = complete && (pslverr != slverr_exp);
    flags[ERR_SLVERR_STRAY]    = pslverr && !complete;
  end

  assign any_flag = |flags;

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state     <= S_IDLE;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      cap_sel   <= '0;
      err_vec   <= '0;
      err_pulse <= '0;
      xfer_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      err_pulse <= flags;
      if (capture) begin
        cap_addr  <= paddr;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
        cap_sel   <= psel;
      end
      if (complete) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      // A violation in the clearing sample survives the clear.
      if (clr) begin
        err_vec <= flags;
        err_cnt <= any_flag ? CNT_W'(1) : '0;
      end else begin
        err_vec <= err_vec | flags;
        if (any_flag && (err_cnt != '1)) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign phase = state;

endmodule
